// File: rtl/qsm_multi_regs.sv
// Wishbone register and readout block for NCHAN quench-signal-monitor DIM channels.
// Per-channel control/status, periodic auto-trigger, sticky W1C flags with IRQ, readout-memory windows.
module qsm_multi_regs #(
   parameter int NCHAN  = 2,
   parameter int MEM_AW = 7,
   localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1,
   localparam int AW = MEM_AW + CW + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_we_i,
   input  logic [AW+1:0]         wb_adr_i,
   input  logic [3:0]            wb_sel_i,
   input  logic [31:0]           wb_dat_i,
   output logic [31:0]           wb_dat_o,
   output logic                  wb_ack_o,
   output logic                  wb_stall_o,
   input  logic                  us_tick_i,
   output logic [NCHAN-1:0]      ctrl_reset_o,
   output logic [NCHAN-1:0]      ctrl_trig_o,
   output logic [4*NCHAN-1:0]    ctrl_last_reg_adr_o,
   output logic [4*NCHAN-1:0]    ctrl_max_dim_no_o,
   output logic [10*NCHAN-1:0]   ctrl_read_delay_o,
   input  logic [NCHAN-1:0]      st_busy_i,
   input  logic [NCHAN-1:0]      st_done_i,
   input  logic [NCHAN-1:0]      st_err_many_i,
   input  logic [NCHAN-1:0]      st_err_fb_i,
   input  logic [4*NCHAN-1:0]    st_dim_count_i,
   output logic [MEM_AW-1:0]     mem_addr_o,
   output logic [NCHAN-1:0]      mem_re_o,
   input  logic [16*NCHAN-1:0]   mem_data_i,
   output logic                  irq_o
);

   logic                    busy_reg, ack_reg, mem_rd_reg, mem_wait_reg, irq_reg;
   logic [31:0]             dat_reg;
   logic [NCHAN-1:0]        mem_re_reg;
   logic [MEM_AW-1:0]       mem_addr_reg;
   logic [CW-1:0]           mem_chan_reg;

   logic                    req, sel_mem, reg_wr;
   logic [CW-1:0]           reg_chan, mem_chan;
   logic [1:0]              reg_idx;
   logic [MEM_AW-1:0]       mem_word;
   logic [NCHAN-1:0]        mem_sel;
   logic [15:0]             mem_rdata;
   logic [31:0]             rd_word;
   logic [NCHAN-1:0][31:0]  ch_rdata;
   logic [NCHAN-1:0]        ch_irq;
   logic                    unused_bits;

   assign unused_bits = ^{wb_sel_i, wb_adr_i[1:0]};

   // Only one transaction in flight: a request is taken when no earlier one is pending.
   assign req        = wb_cyc_i & wb_stb_i & ~busy_reg;
   assign sel_mem    = wb_adr_i[AW+1];
   assign reg_chan   = wb_adr_i[CW+3:4];
   assign reg_idx    = wb_adr_i[3:2];
   assign mem_chan   = wb_adr_i[AW:MEM_AW+2];
   assign mem_word   = wb_adr_i[MEM_AW+1:2];
   assign reg_wr     = req & wb_we_i & ~sel_mem;
   assign wb_stall_o = wb_cyc_i & wb_stb_i & ~wb_ack_o;

   always_comb begin
      rd_word   = 32'd0;
      mem_rdata = 16'd0;
      mem_sel   = '0;
      for (int c = 0; c < NCHAN; c++) begin
         if (reg_chan == CW'(c))     rd_word    = ch_rdata[c];
         if (mem_chan_reg == CW'(c)) mem_rdata  = mem_data_i[16*c +: 16];
         mem_sel[c] = (mem_chan == CW'(c));
      end
   end

   for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
      logic        wr_sel, wr_ctrl, wr_status, wr_period, wr_mask;
      logic [3:0]  last_reg_adr_reg, max_dim_no_reg, mask_reg, sticky_reg;
      logic [9:0]  read_delay_reg;
      logic        auto_en_reg, reset_reg, trig_reg;
      logic [23:0] period_reg, cnt_reg;
      logic [2:0]  prev_reg, lvl;
      logic [3:0]  set_vec, clr_vec;
      logic        cnt_clr, cnt_run, fire;

      assign wr_sel    = reg_wr && (reg_chan == CW'(gi));
      assign wr_ctrl   = wr_sel && (reg_idx == 2'd0);
      assign wr_status = wr_sel && (reg_idx == 2'd1);
      assign wr_period = wr_sel && (reg_idx == 2'd2);
      assign wr_mask   = wr_sel && (reg_idx == 2'd3);

      assign lvl     = {st_err_fb_i[gi], st_err_many_i[gi], st_done_i[gi]};
      assign cnt_clr = wr_ctrl | wr_period;
      assign cnt_run = auto_en_reg & (period_reg != 24'd0);
      // A register write restarts the period, so it also suppresses a fire in that cycle.
      assign fire    = cnt_run & us_tick_i & ~cnt_clr & (cnt_reg == period_reg - 24'd1);
      // Sticky order: {overrun, err_fb, err_many, done}
      assign set_vec = {fire & st_busy_i[gi], lvl & ~prev_reg};
      assign clr_vec = wr_status ? {wb_dat_i[8], wb_dat_i[3:1]} : 4'd0;

      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            last_reg_adr_reg <= '0;
            max_dim_no_reg   <= '0;
            read_delay_reg   <= '0;
            auto_en_reg      <= 1'b0;
            period_reg       <= '0;
            mask_reg         <= '0;
            sticky_reg       <= '0;
            prev_reg         <= '0;
            cnt_reg          <= '0;
            reset_reg        <= 1'b0;
            trig_reg         <= 1'b0;
         end else begin
            if (wr_ctrl) begin
               last_reg_adr_reg <= wb_dat_i[5:2];
               max_dim_no_reg   <= wb_dat_i[9:6];
               read_delay_reg   <= wb_dat_i[19:10];
               auto_en_reg      <= wb_dat_i[20];
            end
            if (wr_period) period_reg <= wb_dat_i[23:0];
            if (wr_mask)   mask_reg   <= wb_dat_i[3:0];
            reset_reg  <= wr_ctrl & wb_dat_i[0];
            trig_reg   <= (wr_ctrl & wb_dat_i[1]) | (fire & ~st_busy_i[gi]);
            prev_reg   <= lvl;
            sticky_reg <= (sticky_reg & ~clr_vec) | set_vec;
            if (cnt_clr || !cnt_run)
               cnt_reg <= '0;
            else if (us_tick_i)
               cnt_reg <= fire ? 24'd0 : cnt_reg + 24'd1;
         end
      end

      assign ch_rdata[gi] =
         (reg_idx == 2'd0) ? {11'd0, auto_en_reg, read_delay_reg, max_dim_no_reg, last_reg_adr_reg, 2'b00} :
         (reg_idx == 2'd1) ? {23'd0, sticky_reg[3], st_dim_count_i[4*gi +: 4], sticky_reg[2:0], st_busy_i[gi]} :
         (reg_idx == 2'd2) ? {8'd0, period_reg} :
                             {28'd0, mask_reg};

      assign ch_irq[gi]                    = |(sticky_reg & mask_reg);
      assign ctrl_reset_o[gi]              = reset_reg;
      assign ctrl_trig_o[gi]               = trig_reg;
      assign ctrl_last_reg_adr_o[4*gi +: 4] = last_reg_adr_reg;
      assign ctrl_max_dim_no_o[4*gi +: 4]   = max_dim_no_reg;
      assign ctrl_read_delay_o[10*gi +: 10] = read_delay_reg;
   end

   // Memory reads run three stages: mem_re issued, data valid at memory, data registered with ack.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         busy_reg     <= 1'b0;
         ack_reg      <= 1'b0;
         dat_reg      <= '0;
         mem_re_reg   <= '0;
         mem_addr_reg <= '0;
         mem_chan_reg <= '0;
         mem_rd_reg   <= 1'b0;
         mem_wait_reg <= 1'b0;
         irq_reg      <= 1'b0;
      end else begin
         ack_reg      <= 1'b0;
         mem_re_reg   <= '0;
         mem_rd_reg   <= 1'b0;
         mem_wait_reg <= mem_rd_reg;
         irq_reg      <= |ch_irq;
         if (ack_reg) busy_reg <= 1'b0;
         if (mem_wait_reg) begin
            ack_reg <= 1'b1;
            dat_reg <= {16'd0, mem_rdata};
         end
         if (req) begin
            busy_reg <= 1'b1;
            if (sel_mem && !wb_we_i) begin
               mem_rd_reg   <= 1'b1;
               mem_re_reg   <= mem_sel;
               mem_addr_reg <= mem_word;
               mem_chan_reg <= mem_chan;
            end else begin
               ack_reg <= 1'b1;
               dat_reg <= (sel_mem || wb_we_i) ? 32'd0 : rd_word;
            end
         end
      end
   end

   assign wb_ack_o   = ack_reg;
   assign wb_dat_o   = dat_reg;
   assign mem_re_o   = mem_re_reg;
   assign mem_addr_o = mem_addr_reg;
   assign irq_o      = irq_reg;

endmodule

// File: tb/tb_qsm_multi_regs.sv
// Bench for qsm_multi_regs (NCHAN=2, MEM_AW=7): vector table, hand-written corner sequences
// and randomized register/memory traffic checked against a field-level reference model.
module tb_qsm_multi_regs;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        wb_cyc_i, wb_stb_i, wb_we_i;
   logic [10:0] wb_adr_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_dat_i, wb_dat_o;
   logic        wb_ack_o, wb_stall_o, us_tick_i, irq_o;
   logic [1:0]  ctrl_reset_o, ctrl_trig_o, mem_re_o;
   logic [7:0]  ctrl_last_reg_adr_o, ctrl_max_dim_no_o, st_dim_count_i;
   logic [19:0] ctrl_read_delay_o;
   logic [1:0]  st_busy_i, st_done_i, st_err_many_i, st_err_fb_i;
   logic [6:0]  mem_addr_o;
   logic [31:0] mem_data_i;

   qsm_multi_regs #(.NCHAN(2), .MEM_AW(7)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
      .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o), .us_tick_i(us_tick_i),
      .ctrl_reset_o(ctrl_reset_o), .ctrl_trig_o(ctrl_trig_o),
      .ctrl_last_reg_adr_o(ctrl_last_reg_adr_o), .ctrl_max_dim_no_o(ctrl_max_dim_no_o),
      .ctrl_read_delay_o(ctrl_read_delay_o),
      .st_busy_i(st_busy_i), .st_done_i(st_done_i), .st_err_many_i(st_err_many_i),
      .st_err_fb_i(st_err_fb_i), .st_dim_count_i(st_dim_count_i),
      .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o), .mem_data_i(mem_data_i), .irq_o(irq_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit          we;
      logic [10:0] adr;
      logic [31:0] wd;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] rd;
   int          lat, re_cyc;
   logic [1:0]  snap_reset, snap_trig, snap_re;
   logic [6:0]  snap_addr;

   // Reference model: register contents as software sees them.
   logic [31:0] ctrl_m [2];
   logic [31:0] period_m [2];
   logic [31:0] mask_m [2];
   logic [31:0] sticky_m [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wb_xfer(input bit we, input logic [10:0] adr, input logic [31:0] wd,
                          output logic [31:0] rdat, output int latency);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wd;
      snap_re = '0; snap_addr = '0; re_cyc = -1; latency = -1; rdat = '0;
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk_i); #1;
         if (mem_re_o != 2'b00 && re_cyc < 0) begin
            snap_re = mem_re_o; snap_addr = mem_addr_o; re_cyc = n;
         end
         if (wb_ack_o) begin
            latency = n; rdat = wb_dat_o; snap_reset = ctrl_reset_o; snap_trig = ctrl_trig_o;
            break;
         end
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      if (latency < 0) begin
         checks++; errors++;
         $display("FAIL wb_ack_timeout: adr 0x%03h got no ack within 10 cycles", adr);
      end
      $display("txn we=%0d adr=0x%03h wdat=0x%08h rdat=0x%08h lat=%0d", we, adr, wd, rdat, latency);
      @(posedge clk_i); #1;
   endtask

   function automatic logic [3:0] stk4(input logic [31:0] s);
      return {s[8], s[3], s[2], s[1]};
   endfunction

   function automatic logic [31:0] exp_reg(input int c, input int r);
      case (r)
         0:       return ctrl_m[c];
         1:       return sticky_m[c] | {31'd0, st_busy_i[c]} | {24'd0, st_dim_count_i[4*c +: 4], 4'd0};
         2:       return period_m[c];
         default: return mask_m[c];
      endcase
   endfunction

   function automatic logic exp_irq();
      logic any = 1'b0;
      for (int c = 0; c < 2; c++) any |= |(stk4(sticky_m[c]) & mask_m[c][3:0]);
      return any;
   endfunction

   vec_t        vt [11];
   int          tc, op, ch, ri, wi;
   logic        exp_tr, ov_exp, got_ack;
   logic [31:0] d, e;
   logic [10:0] a;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{1'b0, 11'h000, 32'h0,         32'h0,         1};
      vt[1]  = '{1'b0, 11'h014, 32'h0,         32'h0,         1};
      vt[2]  = '{1'b1, 11'h008, 32'hFF12_3456, 32'h0,         1};
      vt[3]  = '{1'b0, 11'h008, 32'h0,         32'h0012_3456, 1};
      vt[4]  = '{1'b1, 11'h00C, 32'hFFFF_FFF5, 32'h0,         1};
      vt[5]  = '{1'b0, 11'h00C, 32'h0,         32'h0000_0005, 1};
      vt[6]  = '{1'b0, 11'h01C, 32'h0,         32'h0,         1};
      vt[7]  = '{1'b1, 11'h620, 32'hDEAD_BEEF, 32'h0,         1};
      vt[8]  = '{1'b1, 11'h008, 32'h0,         32'h0,         1};
      vt[9]  = '{1'b0, 11'h008, 32'h0,         32'h0,         1};
      vt[10] = '{1'b0, 11'h608, 32'h0,         32'h0000_5A5A, 3};

      rst_n_i = 1'b0; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_sel_i = 4'hF;
      wb_dat_i = '0; us_tick_i = 0; st_busy_i = '0; st_done_i = '0; st_err_many_i = '0;
      st_err_fb_i = '0; st_dim_count_i = '0; mem_data_i = 32'h5A5A_C3C3;
      repeat (3) @(posedge clk_i);
      #1;
      check("reset_outputs", {25'd0, wb_ack_o, irq_o, ctrl_reset_o, ctrl_trig_o, mem_re_o}, 32'd0);
      check("reset_fields", {ctrl_last_reg_adr_o, ctrl_max_dim_no_o, ctrl_read_delay_o[15:0]}, 32'd0);
      check("reset_dat", wb_dat_o, 32'd0);
      rst_n_i = 1'b1;

      // Table-driven register/memory vectors
      for (int i = 0; i < 11; i++) begin
         wb_xfer(vt[i].we, vt[i].adr, vt[i].wd, rd, lat);
         check($sformatf("vec%0d_latency", i), lat, vt[i].lat);
         if (!vt[i].we) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
      end

      // CONTROL write with pulse bits on channel 1
      wb_xfer(1'b1, 11'h010, 32'h0004_0A3F, rd, lat);
      check("ctrl_reset_pulse", snap_reset, 2'b10);
      check("ctrl_trig_pulse", snap_trig, 2'b10);
      check("ctrl_pulses_end", {ctrl_reset_o, ctrl_trig_o}, 4'b0000);
      check("ctrl_last_reg_adr", ctrl_last_reg_adr_o, 8'hF0);
      check("ctrl_max_dim_no", ctrl_max_dim_no_o, 8'h80);
      check("ctrl_read_delay", ctrl_read_delay_o, {10'h102, 10'h000});
      wb_xfer(1'b0, 11'h010, 32'h0, rd, lat);
      check("ctrl_readback", rd, 32'h0004_0A3C);

      // Sticky done: rising edge, W1C, then edge coinciding with the W1C
      st_done_i[0] = 1'b1;
      @(posedge clk_i); #1;
      st_done_i[0] = 1'b0;
      wb_xfer(1'b0, 11'h004, 32'h0, rd, lat);
      check("done_sticky", rd, 32'h2);
      check("done_irq", irq_o, 1'b1);
      wb_xfer(1'b1, 11'h004, 32'h2, rd, lat);
      check("done_irq_cleared", irq_o, 1'b0);
      wb_xfer(1'b0, 11'h004, 32'h0, rd, lat);
      check("done_w1c", rd, 32'h0);
      st_done_i[0] = 1'b1;
      wb_xfer(1'b1, 11'h004, 32'h2, rd, lat);
      st_done_i[0] = 1'b0; st_busy_i[0] = 1'b1; st_dim_count_i = 8'h05;
      wb_xfer(1'b0, 11'h004, 32'h0, rd, lat);
      check("done_set_wins_live_bits", rd, 32'h53);
      st_busy_i[0] = 1'b0; st_dim_count_i = 8'h00;
      wb_xfer(1'b1, 11'h004, 32'h2, rd, lat);

      // Auto-trigger on channel 0: period 3 ticks, tick every 4 cycles, busy across one fire
      wb_xfer(1'b1, 11'h008, 32'd3, rd, lat);
      wb_xfer(1'b1, 11'h000, 32'h0010_0000, rd, lat);
      tc = 0; exp_tr = 1'b0; ov_exp = 1'b0;
      for (int i = 0; i < 36; i++) begin
         check($sformatf("auto_trig_c%0d", i), {30'd0, ctrl_trig_o}, {31'd0, exp_tr});
         st_busy_i[0] = (i >= 16 && i < 24);
         us_tick_i    = (i % 4 == 0);
         exp_tr       = 1'b0;
         if (us_tick_i) begin
            tc++;
            if (tc % 3 == 0) begin
               if (st_busy_i[0]) ov_exp = 1'b1;
               else              exp_tr = 1'b1;
            end
         end
         @(posedge clk_i); #1;
      end
      check("auto_trig_last", {30'd0, ctrl_trig_o}, {31'd0, exp_tr});
      us_tick_i = 1'b0; st_busy_i = '0;
      wb_xfer(1'b0, 11'h004, 32'h0, rd, lat);
      check("overrun_ch0", rd, ov_exp ? 32'h100 : 32'h0);
      wb_xfer(1'b1, 11'h000, 32'h0, rd, lat);

      // Overrun interrupt on channel 1
      wb_xfer(1'b1, 11'h01C, 32'h8, rd, lat);
      wb_xfer(1'b1, 11'h018, 32'h1, rd, lat);
      wb_xfer(1'b1, 11'h010, 32'h0010_0000, rd, lat);
      st_busy_i[1] = 1'b1; us_tick_i = 1'b1;
      @(posedge clk_i); #1;
      us_tick_i = 1'b0;
      check("irq_not_yet", irq_o, 1'b0);
      check("busy_fire_no_trig", ctrl_trig_o, 2'b00);
      @(posedge clk_i); #1;
      check("irq_overrun", irq_o, 1'b1);
      st_busy_i[1] = 1'b0;
      wb_xfer(1'b1, 11'h010, 32'h0, rd, lat);
      wb_xfer(1'b1, 11'h014, 32'h100, rd, lat);
      check("irq_w1c", irq_o, 1'b0);

      // Memory windows
      mem_data_i = 32'hBEEF_1234;
      wb_xfer(1'b0, 11'h614, 32'h0, rd, lat);
      check("mem_addr", snap_addr, 7'd5);
      check("mem_re", snap_re, 2'b10);
      check("mem_ack_after_re", lat - re_cyc, 2);
      check("mem_data_ch1", rd, 32'h0000_BEEF);
      wb_xfer(1'b0, 11'h5FC, 32'h0, rd, lat);
      check("mem_re_ch0", {snap_re, 1'b0, snap_addr}, {2'b01, 1'b0, 7'h7F});
      check("mem_data_ch0", rd, 32'h0000_1234);

      // Reset asserted while a memory read is in flight
      wb_xfer(1'b1, 11'h018, 32'h000A_BCDE, rd, lat);
      wb_xfer(1'b1, 11'h010, 32'h0004_0A3C, rd, lat);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 11'h614;
      @(posedge clk_i); #1;
      check("midrst_re_started", mem_re_o, 2'b10);
      rst_n_i = 1'b0;
      #1;
      check("midrst_outputs", {25'd0, wb_ack_o, irq_o, ctrl_reset_o, ctrl_trig_o, mem_re_o}, 32'd0);
      check("midrst_fields", {ctrl_max_dim_no_o, ctrl_read_delay_o[19:10], ctrl_last_reg_adr_o}, 32'd0);
      check("midrst_dat", wb_dat_o, 32'd0);
      got_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_i); #1;
         got_ack |= wb_ack_o;
      end
      check("midrst_no_ack", got_ack, 1'b0);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;
      wb_xfer(1'b0, 11'h018, 32'h0, rd, lat);
      check("postrst_period", rd, 32'h0);
      wb_xfer(1'b0, 11'h010, 32'h0, rd, lat);
      check("postrst_ctrl", rd, 32'h0);

      // Randomized traffic against the model (state is all-zero after the reset above)
      for (int c = 0; c < 2; c++) begin
         ctrl_m[c] = '0; period_m[c] = '0; mask_m[c] = '0; sticky_m[c] = '0;
      end
      st_busy_i = 2'($urandom); st_dim_count_i = 8'($urandom);
      for (int k = 0; k < 60; k++) begin
         op = $urandom_range(0, 3); ch = $urandom_range(0, 1); ri = $urandom_range(0, 3);
         d  = $urandom;
         a  = 11'(ch * 16 + ri * 4);
         if (op <= 1) begin
            wb_xfer(1'b1, a, d, rd, lat);
            case (ri)
               0: ctrl_m[ch]   = d & 32'h001F_FFFC;
               1: sticky_m[ch] = sticky_m[ch] & ~(d & 32'h0000_010E);
               2: period_m[ch] = d & 32'h00FF_FFFF;
               default: mask_m[ch] = d & 32'h0000_000F;
            endcase
            check("rnd_reset_pulse", snap_reset, (ri == 0 && d[0]) ? 2'(1 << ch) : 2'b00);
            check("rnd_trig_pulse", snap_trig, (ri == 0 && d[1]) ? 2'(1 << ch) : 2'b00);
            check("rnd_last_reg_adr", ctrl_last_reg_adr_o[4*ch +: 4], (ctrl_m[ch] >> 2) & 32'hF);
            check("rnd_max_dim_no", ctrl_max_dim_no_o[4*ch +: 4], (ctrl_m[ch] >> 6) & 32'hF);
            check("rnd_read_delay", ctrl_read_delay_o[10*ch +: 10], (ctrl_m[ch] >> 10) & 32'h3FF);
            check("rnd_irq", irq_o, exp_irq());
         end else if (op == 2) begin
            wb_xfer(1'b0, a, 32'h0, rd, lat);
            check($sformatf("rnd_read_ch%0d_reg%0d", ch, ri), rd, exp_reg(ch, ri));
         end else begin
            mem_data_i = $urandom;
            wi = $urandom_range(0, 127);
            a  = 11'h400 | 11'(ch << 9) | 11'(wi << 2);
            wb_xfer(1'b0, a, 32'h0, rd, lat);
            e  = (ch == 1) ? (mem_data_i >> 16) : (mem_data_i & 32'hFFFF);
            check("rnd_mem_data", rd, e);
            check("rnd_mem_sel", {snap_re, snap_addr}, {2'(1 << ch), 7'(wi)});
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/qsm_multi_regs.md
# qsm_multi_regs

Parametrised Wishbone register and readout block for NCHAN quench-signal-monitor DIM channels. It sits between the Wishbone crossbar and NCHAN QSPI DIM masters. It provides the existing control/status fields and per-channel readout-memory windows. New over the fixed two-channel version: per-channel periodic auto-trigger, sticky write-1-to-clear status flags, overrun detection and a maskable interrupt.

## Interface
- NCHAN, 2, number of DIM channels; power of two, 1..8; CW = max(1, clog2(NCHAN)).
- MEM_AW, 7, word-address width of each channel's readout memory; must be ≥ CW+2; AW = MEM_AW+CW+1.
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset, released synchronously upstream.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone pipelined slave controls.
- wb_adr_i  in  AW+2  byte address; bits [1:0] ignored.
- wb_sel_i  in  4  ignored; all writes are full-word.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o, wb_stall_o  out  1 each  ack; stall = wb_cyc_i & wb_stb_i & ~wb_ack_o.
- us_tick_i  in  1  one-cycle pulse every microsecond.
- ctrl_reset_o, ctrl_trig_o  out  NCHAN  one-cycle pulses per channel.
- ctrl_last_reg_adr_o, ctrl_max_dim_no_o  out  4·NCHAN  per-channel fields; channel c uses [4c+3:4c].
- ctrl_read_delay_o  out  10·NCHAN  per-channel read delay in µs.
- st_busy_i, st_done_i, st_err_many_i, st_err_fb_i  in  NCHAN  master status levels.
- st_dim_count_i  in  4·NCHAN  detected device count.
- mem_addr_o  out  MEM_AW  shared readout-memory word address.
- mem_re_o  out  NCHAN  per-channel read enable.
- mem_data_i  in  16·NCHAN  per-channel read data; valid the cycle after mem_re_o.
- irq_o  out  1  registered level interrupt.

## Operation
- Region select: adr[AW+1] = 0 selects registers; 1 selects memory. Memory channel = adr[AW:MEM_AW+2]; word = adr[MEM_AW+1:2].
- Register region: channel = adr[CW+3:4], register = adr[3:2]. Unmapped channel indexes read 0, ignore writes and are still acked.
- Reg 0 CONTROL (RW):
  - bit0 reset and bit1 trig: write-1 pulses, read 0.
  - [5:2] last_reg_adr, [9:6] max_dim_no, [19:10] read_delay.
  - bit20 auto_en.
  - Other bits read 0.
- Reg 1 STATUS:
  - Live bits, read only: bit0 busy, [7:4] dim_count.
  - Sticky bits, write-1-to-clear: bit1 done, bit2 err_many, bit3 err_fb, bit8 overrun.
  - done, err_many and err_fb set on a rising edge of the corresponding input; inputs are registered once for edge detection.
  - If a set and a W1C clear land in the same cycle, set wins.
- Reg 2 PERIOD (RW): [23:0] auto-trigger period in µs. Value 0 disables auto-trigger.
- Reg 3 IRQ_MASK (RW): [3:0] enables for done, err_many, err_fb, overrun.
- Auto-trigger, per channel:
  - A 24-bit counter advances on us_tick_i while auto_en=1 and PERIOD≠0. It is held at 0 otherwise.
  - When the counter equals PERIOD−1 on a tick, it wraps to 0 and fires.
  - Fire with busy=0 → one-cycle ctrl_trig_o pulse.
  - Fire with busy=1 → no trig; overrun is set.
  - A write to CONTROL or PERIOD clears the counter.
  - A software trig and an auto fire in the same cycle produce a single pulse.
- irq_o is registered: OR over all channels of (sticky[3:0] & mask[3:0]).
- Memory read: addressed channel gets mem_re_o=1 for one cycle. wb_dat_o[15:0] = data the next cycle; [31:16] = 0. Memory writes are acked and discarded.

## Timing
- Reset values: all outputs 0; all registers, sticky bits, counters and edge-detect flops 0; wb_dat_o = 0.
- Register read: request cycle T → ack and data at T+1.
- Memory read: mem_re_o at T → ack and data at T+2.
- Write: ack at T+1. Register contents and ctrl_* outputs update at T+1.
- Reset/trig pulses last exactly one cycle, at T+1 for a software write.
- At most one outstanding transaction. A new request is accepted only after the previous ack.
- Reset asserted mid-transaction: ack is dropped and all state returns to reset values immediately.

## Test plan
- Write CONTROL ch1 = 0x0004_0A3F → ctrl_reset_o[1] and ctrl_trig_o[1] pulse one cycle; last_reg_adr=0xF, max_dim_no=0x8, read_delay=0x102; readback = 0x0004_0A3C.
- Pulse st_done_i[0]; read STATUS → bit1=1; write 0x2 → bit1 reads 0. Repeat with the rising edge in the same cycle as the W1C write → bit1 stays 1.
- PERIOD ch0 = 3, auto_en=1, tick every 4 cycles → trig pulse every 3 ticks. Hold busy=1 across a fire → no trig and overrun=1.
- IRQ_MASK ch1 = 0x8 and overrun set on ch1 → irq_o=1 one cycle later; W1C 0x100 → irq_o=0.
- Read memory ch1 word 5 with mem_data_i[31:16]=0xBEEF → mem_addr_o=5, mem_re_o=0b10, ack at T+2, data 0x0000_BEEF.
- Assert reset during a memory read → no ack; all outputs 0; subsequent register read returns 0.
